alu_op_sequencer: RTL

//  Multi-cycle controller that drives the register-file/ALU datapath from an instruction stream.

---
 rtl/alu_op_sequencer_if.sv | 30 +++
 rtl/alu_op_sequencer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer_if.sv
// Instruction and result handshake channels between an instruction source and the sequencer.
// The master drives instructions and accepts results; the slave is the sequencer.
interface alu_op_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              instr_valid;
    logic              instr_ready;
    logic              instr_load;
    logic [1:0]        instr_op;
    logic [4:0]        instr_rd;
    logic [4:0]        instr_rs1;
    logic [4:0]        instr_rs2;
    logic [DATA_W-1:0] instr_imm;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [4:0]        res_rd;

    modport master (
        output instr_valid, instr_load, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
        output res_ready,
        input  instr_ready, res_valid, res_data, res_rd
    );

    modport slave (
        input  instr_valid, instr_load, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
        input  res_ready,
        output instr_ready, res_valid, res_data, res_rd
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller: drives register-file/ALU ports for one instruction at a time
// (load-immediate or rd = rs1 op rs2), returns the written value and counts retirements.
module alu_op_sequencer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    alu_op_sequencer_if.slave bus,
    output logic [4:0]        o_a1,
    output logic [4:0]        o_a2,
    output logic [4:0]        o_a3,
    output logic              o_we3,
    output logic [DATA_W-1:0] o_wd3,
    output logic [1:0]        o_opcode,
    input  logic [DATA_W-1:0] i_alu_result,
    output logic [CNT_W-1:0]  o_retired_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_accept;
    logic              w_res_fire;

    logic [4:0]        r_rd;
    logic [4:0]        r_a1;
    logic [4:0]        r_a2;
    logic [4:0]        r_a3;
    logic              r_we3;
    logic [DATA_W-1:0] r_wd3;
    logic [1:0]        r_opcode;
    logic [DATA_W-1:0] r_res_data;
    logic [4:0]        r_res_rd;
    logic [CNT_W-1:0]  r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_res_fire   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = bus.instr_load ? S_WRITE : S_EXEC;
                end
            end
            S_EXEC:  w_state_next = S_WRITE;
            S_WRITE: w_state_next = S_RESP;
            S_RESP: begin
                if (bus.res_ready) begin
                    w_res_fire   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath-facing registers are loaded one cycle ahead of the state that presents them,
    // so every output is a flop and the ALU sees its operands for the whole EXEC cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd       <= '0;
            r_a1       <= '0;
            r_a2       <= '0;
            r_a3       <= '0;
            r_we3      <= 1'b0;
            r_wd3      <= '0;
            r_opcode   <= '0;
            r_res_data <= '0;
            r_res_rd   <= '0;
            r_cnt      <= '0;
        end else begin
            r_we3 <= 1'b0;
            if (w_accept) begin
                r_rd <= bus.instr_rd;
                if (bus.instr_load) begin
                    r_we3 <= 1'b1;
                    r_a3  <= bus.instr_rd;
                    r_wd3 <= bus.instr_imm;
                end else begin
                    r_a1     <= bus.instr_rs1;
                    r_a2     <= bus.instr_rs2;
                    r_opcode <= bus.instr_op;
                end
            end
            if (r_state == S_EXEC) begin
                r_we3 <= 1'b1;
                r_a3  <= r_rd;
                r_wd3 <= i_alu_result;
            end
            if (r_state == S_WRITE) begin
                r_res_data <= r_wd3;
                r_res_rd   <= r_a3;
            end
            if (w_res_fire) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.instr_ready = (r_state == S_IDLE);
    assign bus.res_valid   = (r_state == S_RESP);
    assign bus.res_data    = r_res_data;
    assign bus.res_rd      = r_res_rd;

    assign o_a1          = r_a1;
    assign o_a2          = r_a2;
    assign o_a3          = r_a3;
    assign o_we3         = r_we3;
    assign o_wd3         = r_wd3;
    assign o_opcode      = r_opcode;
    assign o_retired_cnt = r_cnt;

endmodule
